// File: rtl/mmio_uart_tx_if.sv
// CPU-side MMIO bus for mmio_uart_tx: address, write data/strobe, registered read data and select.
// The read-data signal is named dout because "do" is a reserved SystemVerilog keyword.
interface mmio_uart_tx_if;
  logic [15:0] addr;
  logic [7:0]  di;
  logic        we;
  logic [7:0]  dout;
  logic        sel;

  modport master (
    output addr,
    output di,
    output we,
    input  dout,
    input  sel
  );

  modport slave (
    input  addr,
    input  di,
    input  we,
    output dout,
    output sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS registers, transmit FIFO, 8N1 serial framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 framing).
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Address decode
  logic hit_data_c;
  logic hit_status_c;
  logic wr_data_c;
  logic wr_status_c;

  assign hit_data_c   = (bus.addr == BASE_ADDR);
  assign hit_status_c = (bus.addr == STATUS_ADDR);
  assign wr_data_c    = bus.we & hit_data_c;
  assign wr_status_c  = bus.we & hit_status_c;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             empty_c;
  logic             full_c;
  logic             push_c;
  logic             pop_c;
  logic [7:0]       head_c;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(FIFO_DEPTH));
  assign head_c  = mem[rd_ptr];
  // A simultaneous pop frees the slot being written, so a full FIFO can still accept
  assign push_c  = wr_data_c & (~full_c | pop_c);

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a dropped write in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_data_c & ~push_c) begin
      overflow <= 1'b1;
    end else if (wr_status_c) begin
      overflow <= 1'b0;
    end
  end

  // Transmit FSM state
  logic [2:0]       state;
  logic [2:0]       state_d;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_d;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] bit_idx_d;
  logic [7:0]       shift;
  logic [7:0]       shift_d;
  logic             tx_d;
  logic             busy_c;
  logic             timer_last_c;
`ifdef UART_TX_PARITY_EN
  logic             par;
  logic             par_d;
`endif

  assign busy_c       = (state != S_IDLE);
  assign timer_last_c = (timer == TMR_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par     <= par_d;
`endif
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after this edge
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    tx_d      = tx;
    pop_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par;
`endif

    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = head_c;
          state_d = S_START;
          timer_d = '0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head_c;
`endif
        end
      end

      S_START: begin
        if (timer_last_c) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          tx_d      = shift[0];
          shift_d   = {1'b0, shift[7:1]};
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end

      S_DATA: begin
        if (timer_last_c) begin
          timer_d = '0;
          if (bit_idx == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx + IDX_W'(1);
            tx_d      = shift[0];
            shift_d   = {1'b0, shift[7:1]};
          end
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_last_c) begin
          timer_d = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (timer_last_c) begin
          timer_d = '0;
          // Chain straight into the next frame when data is waiting
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = head_c;
            state_d = S_START;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head_c;
`endif
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Registered read port, one-cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dout <= 8'h00;
      bus.sel  <= 1'b0;
    end else if (hit_status_c) begin
      bus.dout <= {4'b0000, overflow, busy_c, full_c, empty_c};
      bus.sel  <= 1'b1;
    end else if (hit_data_c) begin
      bus.dout <= 8'h00;
      bus.sel  <= 1'b1;
    end else begin
      bus.dout <= 8'h00;
      bus.sel  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table plus hand-written frame sequences.
// Build with UART_TX_PARITY_EN defined for both files to exercise the parity frame.
module tb_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CYC = 44;
`else
  localparam int FRAME_CYC = 40;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  di;
    logic        we;
    logic [7:0]  exp_do;
    logic        exp_sel;
    logic        exp_tx;
  } vec_t;

  logic clk;
  logic rst;
  logic tx;
  int   errors;
  int   checks;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR    (16'hFF00),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
    bus.addr = a;
    bus.di   = d;
    bus.we   = w;
    @(posedge clk);
    #1;
    bus.addr = 16'h0000;
    bus.di   = 8'h00;
    bus.we   = 1'b0;
  endtask

  task automatic capture(input int n, output logic [43:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      v[i] = tx;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Expected tx level per cycle, first cycle of the start bit in bit 0
  function automatic logic [43:0] exp_frame(input logic [7:0] b);
    logic [10:0] bits;
    logic [43:0] v;
    int          nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
    nb      = 11;
`else
    nb      = 10;
`endif
    v = '0;
    for (int i = 0; i < nb * CPB; i++) begin
      v[i] = bits[i / CPB];
    end
    return v;
  endfunction

  vec_t        vecs [8];
  logic [43:0] f0;
  logic [43:0] f1;
  logic [43:0] f2;
  int          lows;

  initial begin
    errors   = 0;
    checks   = 0;
    bus.addr = 16'h0000;
    bus.di   = 8'h00;
    bus.we   = 1'b0;
    rst      = 1'b1;

    vecs[0] = '{16'hFF00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{16'hFF01, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[2] = '{16'h1234, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{16'hFF02, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{16'hFF01, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[5] = '{16'hFEFF, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{16'hFF01, 8'h3C, 1'b1, 8'h01, 1'b1, 1'b1};
    vecs[7] = '{16'hFF01, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1};

    // Reset state while rst is held
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_tx", 48'(tx), 48'h1);
    check("rst_do", 48'(bus.dout), 48'h00);
    check("rst_sel", 48'(bus.sel), 48'h0);
    rst = 1'b0;

    // Register-access vectors, no frame started
    for (int i = 0; i < 8; i++) begin
      bus_cycle(vecs[i].addr, vecs[i].di, vecs[i].we);
      check($sformatf("vec%0d_do", i), 48'(bus.dout), 48'(vecs[i].exp_do));
      check($sformatf("vec%0d_sel", i), 48'(bus.sel), 48'(vecs[i].exp_sel));
      check($sformatf("vec%0d_tx", i), 48'(tx), 48'(vecs[i].exp_tx));
    end

    // Single frame from idle
    bus_cycle(16'hFF00, 8'hA5, 1'b1);
    capture(FRAME_CYC, f0);
    check("frame_a5", 48'(f0), 48'(exp_frame(8'hA5)));
    bus_cycle(16'h0000, 8'h00, 1'b0);
    check("idle_after_a5", 48'(tx), 48'h1);
    bus_cycle(16'hFF01, 8'h00, 1'b0);
    check("status_after_a5", 48'(bus.dout), 48'h01);

    // Second byte during active pop leaves one queued
    do_reset();
    bus_cycle(16'hFF00, 8'h01, 1'b1);
    bus_cycle(16'hFF00, 8'h01, 1'b1);
    bus_cycle(16'hFF01, 8'h00, 1'b0);
    check("status_busy_one", 48'(bus.dout), 48'h04);
    check("status_busy_sel", 48'(bus.sel), 48'h1);
    repeat (2 * FRAME_CYC + 4) bus_cycle(16'h0000, 8'h00, 1'b0);
    bus_cycle(16'hFF01, 8'h00, 1'b0);
    check("status_drained", 48'(bus.dout), 48'h01);

    // Overflow on the fifth write into a four-deep FIFO
    do_reset();
    bus_cycle(16'hFF00, 8'h11, 1'b1);
    bus_cycle(16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus_cycle(16'hFF00, 8'(8'h20 + i), 1'b1);
    end
    bus_cycle(16'hFF01, 8'h00, 1'b0);
    check("status_overflow", 48'(bus.dout), 48'h0E);
    bus_cycle(16'hFF01, 8'hFF, 1'b1);
    bus_cycle(16'hFF01, 8'h00, 1'b0);
    check("status_ovf_clear", 48'(bus.dout), 48'h06);

    // Back-to-back frames with no idle gap
    do_reset();
    bus_cycle(16'hFF00, 8'h5A, 1'b1);
    fork
      begin
        capture(FRAME_CYC, f0);
        capture(FRAME_CYC, f1);
        capture(FRAME_CYC, f2);
      end
      begin
        bus_cycle(16'hFF00, 8'hC3, 1'b1);
        bus_cycle(16'hFF00, 8'h0F, 1'b1);
      end
    join
    check("b2b_frame0", 48'(f0), 48'(exp_frame(8'h5A)));
    check("b2b_frame1", 48'(f1), 48'(exp_frame(8'hC3)));
    check("b2b_frame2", 48'(f2), 48'(exp_frame(8'h0F)));
    bus_cycle(16'h0000, 8'h00, 1'b0);
    bus_cycle(16'hFF01, 8'h00, 1'b0);
    check("status_after_b2b", 48'(bus.dout), 48'h01);

    // Frame carrying 8'h07 (parity bit 1 when enabled)
    bus_cycle(16'hFF00, 8'h07, 1'b1);
    capture(FRAME_CYC, f0);
    check("frame_07", 48'(f0), 48'(exp_frame(8'h07)));
`ifdef UART_TX_PARITY_EN
    check("parity_07", 48'(f0[9*CPB]), 48'h1);
`endif
    bus_cycle(16'h0000, 8'h00, 1'b0);

    // Reset at cycle 12 of a frame aborts it and flushes queued data
    bus_cycle(16'hFF00, 8'h00, 1'b1);
    bus_cycle(16'hFF00, 8'h81, 1'b1);
    capture(11, f0);
    bus_cycle(16'hFF00, 8'h82, 1'b1);
    check("pre_rst_bits", 48'(f0[10:0]), 48'(exp_frame(8'h00) & 44'h7FF));
    rst = 1'b1;
    #1;
    check("rst_mid_tx", 48'(tx), 48'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_tx", 48'(tx), 48'h1);
    bus_cycle(16'hFF01, 8'h00, 1'b0);
    check("post_rst_status", 48'(bus.dout), 48'h01);
    lows = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(posedge clk);
      #1;
      if (tx == 1'b0) lows++;
    end
    check("no_start_after_rst", 48'(lows), 48'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'hFF00, giving the bus address of the DATA register; STATUS is at BASE_ADDR+1.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles per serial bit (legal range 1..255).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the transmit FIFO depth (power of two, 2..16).
REQ-004 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port addr, input, 16 bits: CPU bus address.
REQ-007 Port di, input, 8 bits: write data from the CPU.
REQ-008 Port we, input, 1 bit: CPU write strobe, sampled on the rising clk edge.
REQ-009 Port do, output, 8 bits: registered read data to the CPU.
REQ-010 Port sel, output, 1 bit: registered flag, high when do carries valid data for the top-level read mux.
REQ-011 Port tx, output, 1 bit: serial line; idles high.

Function
REQ-012 Address decode SHALL be hit = (addr == BASE_ADDR) or (addr == BASE_ADDR+1); any other address causes no state change.
REQ-013 Read latency SHALL be one cycle, as with ram: on a hit, do and sel update on the edge after addr is presented; on a miss, sel = 0 and do = 8'h00.
REQ-014 A read of DATA SHALL return 8'h00.
REQ-015 A read of STATUS SHALL return {4'b0, overflow, busy, full, empty}, sampled at the edge.
REQ-016 A write to DATA (we = 1, hit) SHALL push di into the FIFO if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-017 Otherwise the write SHALL be dropped and the sticky overflow flag set.
REQ-018 A write of any value to STATUS SHALL clear overflow; if clearing and setting occur in the same cycle, setting wins.
REQ-019 The FIFO SHALL track its fill with a count of width clog2(FIFO_DEPTH)+1 and wrapping read/write pointers.
REQ-020 empty SHALL equal (count == 0), and full SHALL equal (count == FIFO_DEPTH).
REQ-021 The TX FSM SHALL have states IDLE, START, DATA, PARITY (present only with the macro) and STOP, with a bit-timer and a 3-bit bit-index.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into the shift register and enter START on the next edge; tx = 1 throughout IDLE.
REQ-023 START SHALL drive tx = 0 for CLKS_PER_BIT cycles.
REQ-024 DATA SHALL drive the byte LSB first, each bit for CLKS_PER_BIT cycles.
REQ-025 STOP SHALL drive tx = 1 for CLKS_PER_BIT cycles.
REQ-026 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and go directly to START (no idle gap); otherwise it SHALL return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 tx SHALL be driven from a register, glitch-free.

Reset
REQ-029 While rst = 1, the FSM SHALL be in IDLE, and tx = 1, do = 8'h00, sel = 0.
REQ-030 While rst = 1, count, both pointers, overflow, the timer and the bit-index SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, drive tx = 1 and discard all FIFO contents.

Configuration
REQ-032 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; a frame is then 11 bits.
REQ-033 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, DATA goes directly to STOP, and a frame is 10 bits.

Verification
REQ-034 Idle write: after reset, write 8'hA5 to FF00 -> tx low one edge later for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; total 40 cycles with no parity.
REQ-035 Status read: write 8'h01 twice back-to-back, then read FF01 -> do = 8'h04 (busy, FIFO holds 1 after the first pop), with sel = 1 one cycle after the address.
REQ-036 Overflow: with the first byte already popped, write 5 more bytes in consecutive cycles -> 4 accepted, overflow set, STATUS = 8'h0E; then write FF01 -> STATUS = 8'h06.
REQ-037 Back-to-back frames: queue 3 bytes -> 3 consecutive frames with tx never high for more than 4 cycles between start bits; STATUS = 8'h01 after the final stop bit.
REQ-038 Reset mid-frame: assert rst at cycle 12 of a frame -> tx = 1 and STATUS = 8'h01 immediately after rst falls; no further start bit appears.
REQ-039 Parity build: with UART_TX_PARITY_EN defined, send 8'h07 -> parity bit = 1 and frame length = 44 cycles.
